decode_stage: RTL
=================

# decode_stage

RV32I instruction decode stage. It takes fetched instructions over a valid/ready handshake and drives the register file read addresses. It bypasses same-cycle writeback data, decodes immediates and control fields, and detects load-use hazards. Results are captured into the ID/EX pipeline register that feeds the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- sysclk  in  1  system clock, all state on rising edge
- sysreset_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch holds a valid instruction
- if_ready  out  1  decode accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- rs1_addr  out  5  register file read address 1, equal to if_instr[19:15]
- rs2_addr  out  5  register file read address 2, equal to if_instr[24:20]
- rs1  in  32  register file read data 1 (combinational)
- rs2  in  32  register file read data 2 (combinational)
- wb_we  in  1  writeback writes the register file this cycle
- wb_rd_addr  in  5  writeback destination
- wb_rd_data  in  32  writeback data
- flush  in  1  branch/jump redirect; kill the in-flight decode
- ex_ready  in  1  execute accepts the ID/EX contents
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_pc  out  32  instruction PC
- ex_rs1_data, ex_rs2_data  out  32 each  operand values after bypass
- ex_rs1_addr, ex_rs2_addr  out  5 each  source addresses, used by the execute forwarding unit
- ex_imm  out  32  sign-extended immediate
- ex_rd_addr  out  5  destination register
- ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1 (instr[30])
- ex_rd_we  out  1  instruction writes rd
- ex_is_load  out  1  opcode 0000011
- ex_illegal  out  1  unsupported opcode

## Operation
- **Decode (combinational on if_instr).** Immediate formats:
  - I: instr[31:20] sign-extended; opcodes 0010011, 0000011, 1100111, 1110011.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: imm = 0.
- **Legal opcodes.** 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 0001111, 1110011.
  - Any other opcode sets ex_illegal=1 and ex_rd_we=0.
- **rd write enable.** rd_we = 1 for R, I, load, LUI, AUIPC, JAL, JALR when rd != 0. It is 0 for S, B, FENCE, SYSTEM, and whenever rd = 0.
- **Source usage flags.**
  - uses_rs1: all formats except U and J.
  - uses_rs2: R, S, B only.
  - An unused operand is captured as 0, and its address field is captured as 0.
- **Bypass.** If wb_we=1, wb_rd_addr!=0 and wb_rd_addr equals rs1_addr, the captured operand is wb_rd_data instead of rs1. The same rule applies to rs2. Address 0 always yields 0.
- **Load-use hazard.** hazard = ex_valid & ex_is_load & ex_rd_we & ((uses_rs1 & ex_rd_addr==rs1_addr) | (uses_rs2 & ex_rd_addr==rs2_addr)).
- **Handshake.**
  - if_ready = ~flush & ~hazard & (~ex_valid | ex_ready).
  - Accept = if_valid & if_ready.
- **ID/EX update rules, in priority order:**
  1. flush: ex_valid <= 0, all other fields held.
  2. Accept: load all fields, ex_valid <= 1.
  3. ex_ready & (hazard | ~if_valid): ex_valid <= 0 (bubble).
  4. Otherwise: hold all fields.
- **Reset.** While sysreset_n=0, all ex_* outputs are 0 and if_ready is 0. Reset asserted mid-operation discards the held instruction immediately, without waiting for a clock edge.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- Throughput is 1 instruction per cycle when ex_ready=1 and no hazard is present.
- A load-use hazard costs exactly 1 bubble. Once the load leaves ID/EX, the dependent instruction is accepted on the next edge.
- Backpressure: while ex_valid=1 and ex_ready=0, ex_* fields are stable and if_ready=0.
- Flush takes effect on the next edge. In the flush cycle if_ready=0, so no instruction is accepted. Flush overrides a simultaneous accept or hazard.
- Writeback coinciding with decode of the same register is bypassed in that cycle. The register file write becomes visible only from the next cycle.
- rs1_addr/rs2_addr track if_instr combinationally, including while stalled.

## Test plan
- Reset: hold sysreset_n=0 mid-stream → ex_valid=0 and ex_imm=0 asynchronously. After release, the first ADDI x1,x0,5 (0x00500093) gives ex_imm=5, ex_rd_addr=1, ex_rd_we=1 one cycle later.
- Immediates: SW x2,-4(x3), BEQ offset -8, LUI 0x12345, JAL offset +2048 → ex_imm = 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000, 0x00000800.
- Bypass: decode ADD x5,x1,x2 with rs1=0x11, wb_we=1, wb_rd_addr=1, wb_rd_data=0xAA → ex_rs1_data=0xAA. With wb_rd_addr=0 instead, ex_rs1_data=0x11.
- Load-use: LW x4,0(x1) followed by ADD x6,x4,x4 → one cycle with if_ready=0 and ex_valid=0 (bubble), then ADD is accepted. ADD x6,x0,x0 after the same load → no stall.
- Backpressure/flush: ex_ready=0 for 3 cycles → ex_* stable and if_ready=0. Asserting flush with if_valid=1 → ex_valid=0 next cycle and the instruction is not accepted.
- Illegal/x0: opcode 0x7F → ex_illegal=1, ex_rd_we=0. ADDI x0,x0,0 → ex_rd_we=0, ex_illegal=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute bus for the RV32I decode stage. The slave modport is the
// decode stage itself; the master modport is its environment (fetch, register
// file, writeback and execute).
interface decode_stage_if #(
  parameter int XLEN = 32
);

  // fetch handshake
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  // register file read port
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;

  // writeback port (bypassed into decode)
  logic            wb_we;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;

  // redirect and execute handshake
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;

  // ID/EX contents
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_rs1_addr;
  logic [4:0]      ex_rs2_addr;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd_addr;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_rd_we;
  logic            ex_is_load;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, rs1, rs2,
    input  wb_we, wb_rd_addr, wb_rd_data, flush, ex_ready,
    output if_ready, rs1_addr, rs2_addr, ex_valid,
    output ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
    output ex_imm, ex_rd_addr, ex_opcode, ex_funct3, ex_funct7b5,
    output ex_rd_we, ex_is_load, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, rs1, rs2,
    output wb_we, wb_rd_addr, wb_rd_data, flush, ex_ready,
    input  if_ready, rs1_addr, rs2_addr, ex_valid,
    input  ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
    input  ex_imm, ex_rd_addr, ex_opcode, ex_funct3, ex_funct7b5,
    input  ex_rd_we, ex_is_load, ex_illegal
  );

endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads and bypasses the
// source operands, detects load-use hazards against the instruction sitting in
// ID/EX and captures the result into the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic          sysclk,
  input  logic          sysreset_n,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            rd_we;
    logic            is_load;
    logic            illegal;
  } idex_t;

  // Operand selection: unused operand or x0 reads as zero, a same-cycle
  // writeback to the source register wins over the register file.
  function automatic logic [XLEN-1:0] operand_sel(
    input logic            used,
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_we,
    input logic [4:0]      wb_addr,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] val;
    if (!used || (addr == 5'd0)) begin
      val = {XLEN{1'b0}};
    end else if (wb_we && (wb_addr == addr)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  logic [31:0]     instr_s;
  logic [6:0]      opcode_s;
  logic [4:0]      rd_s;
  logic [4:0]      rs1a_s;
  logic [4:0]      rs2a_s;
  logic [31:0]     imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0]     imm_s;
  logic            uses_rs1_s, uses_rs2_s, wr_fmt_s, is_load_s, illegal_s;
  logic            rd_we_s;
  logic            hazard_s, if_ready_s, accept_s;
  idex_t           new_s;
  idex_t           idex_d, idex_q;
  logic            ex_valid_d, ex_valid_q;

  assign instr_s  = bus.if_instr;
  assign opcode_s = instr_s[6:0];
  assign rd_s     = instr_s[11:7];
  assign rs1a_s   = instr_s[19:15];
  assign rs2a_s   = instr_s[24:20];

  assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                    instr_s[11:8], 1'b0};
  assign imm_u_s = {instr_s[31:12], 12'd0};
  assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                    instr_s[30:21], 1'b0};

  // Opcode decode: immediate format, source usage and rd-writing class.
  always_comb begin
    imm_s      = 32'd0;
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    wr_fmt_s   = 1'b0;
    is_load_s  = 1'b0;
    illegal_s  = 1'b0;
    case (opcode_s)
      OP_OP: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        wr_fmt_s   = 1'b1;
      end
      OP_IMM: begin
        imm_s      = imm_i_s;
        uses_rs1_s = 1'b1;
        wr_fmt_s   = 1'b1;
      end
      OP_LOAD: begin
        imm_s      = imm_i_s;
        uses_rs1_s = 1'b1;
        wr_fmt_s   = 1'b1;
        is_load_s  = 1'b1;
      end
      OP_STORE: begin
        imm_s      = imm_s_s;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OP_BRANCH: begin
        imm_s      = imm_b_s;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_s    = imm_u_s;
        wr_fmt_s = 1'b1;
      end
      OP_JAL: begin
        imm_s    = imm_j_s;
        wr_fmt_s = 1'b1;
      end
      OP_JALR: begin
        imm_s      = imm_i_s;
        uses_rs1_s = 1'b1;
        wr_fmt_s   = 1'b1;
      end
      OP_FENCE: begin
        uses_rs1_s = 1'b1;
      end
      OP_SYSTEM: begin
        imm_s      = imm_i_s;
        uses_rs1_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  assign rd_we_s = wr_fmt_s & (rd_s != 5'd0);

  // A load in ID/EX whose rd feeds a used source of this instruction must stall.
  assign hazard_s = ex_valid_q & idex_q.is_load & idex_q.rd_we &
                    ((uses_rs1_s & (idex_q.rd_addr == rs1a_s)) |
                     (uses_rs2_s & (idex_q.rd_addr == rs2a_s)));

  assign if_ready_s = ~bus.flush & ~hazard_s & (~ex_valid_q | bus.ex_ready);
  assign accept_s   = bus.if_valid & if_ready_s;

  // Assemble the ID/EX record for the instruction currently on the fetch bus.
  always_comb begin
    new_s          = '{default: '0};
    new_s.pc       = bus.if_pc;
    new_s.rs1_data = operand_sel(uses_rs1_s, rs1a_s, bus.rs1, bus.wb_we,
                                 bus.wb_rd_addr, bus.wb_rd_data);
    new_s.rs2_data = operand_sel(uses_rs2_s, rs2a_s, bus.rs2, bus.wb_we,
                                 bus.wb_rd_addr, bus.wb_rd_data);
    new_s.rs1_addr = uses_rs1_s ? rs1a_s : 5'd0;
    new_s.rs2_addr = uses_rs2_s ? rs2a_s : 5'd0;
    new_s.imm      = imm_s;
    new_s.rd_addr  = rd_s;
    new_s.opcode   = opcode_s;
    new_s.funct3   = instr_s[14:12];
    new_s.funct7b5 = instr_s[30];
    new_s.rd_we    = rd_we_s;
    new_s.is_load  = is_load_s;
    new_s.illegal  = illegal_s;
  end

  // ID/EX next state: flush beats accept, accept beats bubble, else hold.
  always_comb begin
    idex_d     = idex_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (accept_s) begin
      idex_d     = new_s;
      ex_valid_d = 1'b1;
    end else if (bus.ex_ready && (hazard_s || !bus.if_valid)) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // ID/EX pipeline register; reset clears it without waiting for a clock.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      idex_q     <= '{default: '0};
      ex_valid_q <= 1'b0;
    end else begin
      idex_q     <= idex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  // Ready is forced low while reset is held so nothing is offered a handshake.
  assign bus.if_ready    = if_ready_s & sysreset_n;
  assign bus.rs1_addr    = rs1a_s;
  assign bus.rs2_addr    = rs2a_s;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = idex_q.pc;
  assign bus.ex_rs1_data = idex_q.rs1_data;
  assign bus.ex_rs2_data = idex_q.rs2_data;
  assign bus.ex_rs1_addr = idex_q.rs1_addr;
  assign bus.ex_rs2_addr = idex_q.rs2_addr;
  assign bus.ex_imm      = idex_q.imm;
  assign bus.ex_rd_addr  = idex_q.rd_addr;
  assign bus.ex_opcode   = idex_q.opcode;
  assign bus.ex_funct3   = idex_q.funct3;
  assign bus.ex_funct7b5 = idex_q.funct7b5;
  assign bus.ex_rd_we    = idex_q.rd_we;
  assign bus.ex_is_load  = idex_q.is_load;
  assign bus.ex_illegal  = idex_q.illegal;

endmodule
